// File: rtl/rvb_bmat_arbiter.sv
// Two-requester round-robin front end for one shared in-order bit-matrix unit.
// A tag FIFO records which requester owns each outstanding op so results route back.
module rvb_bmat_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_rs1,
  input  logic [2*XLEN-1:0] req_rs2,
  input  logic [1:0]        req_insn30,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_rd,
  output logic              u_din_valid,
  input  logic              u_din_ready,
  output logic [XLEN-1:0]   u_din_rs1,
  output logic [XLEN-1:0]   u_din_rs2,
  output logic              u_din_insn30,
  input  logic              u_dout_valid,
  output logic              u_dout_ready,
  input  logic [XLEN-1:0]   u_dout_rd,
  output logic              err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic             prio_r;
  logic [DEPTH-1:0] tag_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             err_r;

  logic grant_s;
  logic room_s;
  logic empty_s;
  logic head_s;
  logic issue_s;
  logic retire_s;

  // Issue side: grant, operand mux and request handshakes
  always_comb begin
    grant_s      = 1'b0;
    req_ready    = 2'b00;
    room_s       = (count_r < DEPTH_C);
    if (req_valid == 2'b11) begin
      grant_s = prio_r;
    end else begin
      grant_s = req_valid[1];
    end
    u_din_valid  = (|req_valid) && room_s;
    if (u_din_ready && room_s) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    u_din_rs1    = grant_s ? req_rs1[XLEN +: XLEN] : req_rs1[0 +: XLEN];
    u_din_rs2    = grant_s ? req_rs2[XLEN +: XLEN] : req_rs2[0 +: XLEN];
    u_din_insn30 = grant_s ? req_insn30[1] : req_insn30[0];
    issue_s      = u_din_valid && u_din_ready;
  end

  // Return side: route the unit result to the owner of the FIFO head
  always_comb begin
    rsp_valid    = 2'b00;
    u_dout_ready = 1'b0;
    empty_s      = (count_r == {CW{1'b0}});
    head_s       = tag_r[rd_ptr_r];
    if (!empty_s) begin
      rsp_valid    = head_s ? {u_dout_valid, 1'b0} : {1'b0, u_dout_valid};
      u_dout_ready = rsp_ready[head_s];
    end else begin
      rsp_valid    = 2'b00;
      u_dout_ready = 1'b0;
    end
    rsp_rd   = u_dout_rd;
    retire_s = u_dout_valid && u_dout_ready;
  end

  // Round-robin priority, tag FIFO and occupancy; a full FIFO never bypasses
  always_ff @(posedge clock) begin
    if (!reset) begin
      prio_r   <= 1'b0;
      tag_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (issue_s) begin
        prio_r          <= ~grant_s;
        tag_r[wr_ptr_r] <= grant_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (retire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({issue_s, retire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a result arriving with nothing outstanding
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (u_dout_valid && empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;

endmodule

// File: tb/tb_rvb_bmat_arbiter.sv
// Scoreboard bench for rvb_bmat_arbiter: random requesters, a behavioural shared
// unit, and a matrix-product reference model checked per returned result.
`timescale 1ns/1ps
module tb_rvb_bmat_arbiter;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_rs1;
  logic [2*XLEN-1:0] req_rs2;
  logic [1:0]        req_insn30;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [XLEN-1:0]   rsp_rd;
  logic              u_din_valid;
  logic              u_din_ready;
  logic [XLEN-1:0]   u_din_rs1;
  logic [XLEN-1:0]   u_din_rs2;
  logic              u_din_insn30;
  logic              u_dout_valid;
  logic              u_dout_ready;
  logic [XLEN-1:0]   u_dout_rd;
  logic              err;

  rvb_bmat_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_insn30(req_insn30),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .u_din_valid(u_din_valid), .u_din_ready(u_din_ready),
    .u_din_rs1(u_din_rs1), .u_din_rs2(u_din_rs2), .u_din_insn30(u_din_insn30),
    .u_dout_valid(u_dout_valid), .u_dout_ready(u_dout_ready), .u_dout_rd(u_dout_rd),
    .err(err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [63:0] rs1; logic [63:0] rs2; logic x; } op_t;
  typedef struct { logic tag; logic [63:0] rd; } exp_t;
  typedef struct { logic [63:0] rd; int due; } uop_t;

  op_t  rq0[$];
  op_t  rq1[$];
  exp_t sb[$];
  uop_t uq[$];
  int   tag_log[$];

  logic [1:0]  cur_v = 2'b00;
  logic [63:0] cur_rs1 [2];
  logic [63:0] cur_rs2 [2];
  logic        cur_x [2];
  logic [1:0]  acc = 2'b00;

  int   cyc = 0;
  int   n_out = 0;
  logic prio_m = 1'b0;
  logic err_m = 1'b0;
  logic iss_f = 1'b0;
  logic ret_f = 1'b0;
  logic err_f = 1'b0;
  logic g_f = 1'b0;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int iss_cnt [2] = '{0, 0};

  int         p_req = 100;
  int         p_dinr = 100;
  int         p_rspr = 100;
  int         lat = 0;
  logic       hold = 1'b0;
  logic       rspr_fix_en = 1'b0;
  logic [1:0] rspr_fix = 2'b00;

  // 8x8 GF(2) (xor) or boolean (or) matrix product: row i of a times column j of b
  function automatic logic [63:0] bmat_ref(input logic [63:0] a, input logic [63:0] b, input logic x);
    logic [63:0] r;
    int ones;
    r = 64'd0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(a[i*8+k] & b[k*8+j]);
        r[i*8+j] = x ? ones[0] : (ones != 0);
      end
    end
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.rs1 = {$urandom, $urandom};
    o.rs2 = {$urandom, $urandom};
    o.x   = 1'($urandom_range(1));
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Requester and shared-unit stimulus driver, one step per cycle
  initial forever begin
    op_t op;
    @(posedge clock);
    #1;
    if (reset !== 1'b1) begin
      rq0.delete();
      rq1.delete();
      cur_v        = 2'b00;
      req_valid    = 2'b00;
      rsp_ready    = 2'b00;
      u_din_ready  = 1'b0;
      u_dout_valid = 1'b0;
      u_dout_rd    = 64'd0;
    end else begin
      cur_v = cur_v & ~acc;
      if (!cur_v[0] && rq0.size() > 0 && int'($urandom_range(99)) < p_req) begin
        op = rq0.pop_front();
        cur_rs1[0] = op.rs1; cur_rs2[0] = op.rs2; cur_x[0] = op.x; cur_v[0] = 1'b1;
      end
      if (!cur_v[1] && rq1.size() > 0 && int'($urandom_range(99)) < p_req) begin
        op = rq1.pop_front();
        cur_rs1[1] = op.rs1; cur_rs2[1] = op.rs2; cur_x[1] = op.x; cur_v[1] = 1'b1;
      end
      req_valid   = cur_v;
      req_rs1     = {cur_rs1[1], cur_rs1[0]};
      req_rs2     = {cur_rs2[1], cur_rs2[0]};
      req_insn30  = {cur_x[1], cur_x[0]};
      u_din_ready = (int'($urandom_range(99)) < p_dinr);
      rsp_ready   = rspr_fix_en ? rspr_fix :
                    {(int'($urandom_range(99)) < p_rspr), (int'($urandom_range(99)) < p_rspr)};
      u_dout_valid = !hold && uq.size() > 0 && uq[0].due <= cyc;
      u_dout_rd    = (uq.size() > 0) ? uq[0].rd : 64'd0;
    end
  end

  // Model state: outstanding count, priority and sticky error, per rising edge
  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset !== 1'b1) begin
      n_out = 0; prio_m = 1'b0; err_m = 1'b0;
    end else begin
      n_out = n_out + int'(iss_f) - int'(ret_f);
      if (iss_f) prio_m = ~g_f;
      if (err_f) err_m = 1'b1;
    end
  end

  // Shared unit: in-order, fixed latency, computes from the operands the DUT issued
  initial forever begin
    uop_t u;
    @(negedge clock);
    if (reset !== 1'b1) begin
      uq.delete();
    end else begin
      if (u_dout_valid && u_dout_ready && uq.size() > 0) uq.delete(0);
      if (u_din_valid && u_din_ready) begin
        u.rd  = bmat_ref(u_din_rs1, u_din_rs2, u_din_insn30);
        u.due = cyc + 1 + lat;
        uq.push_back(u);
      end
    end
  end

  // Issue monitor: grant/handshake checks and scoreboard push
  initial forever begin
    logic g;
    logic room;
    exp_t e;
    @(negedge clock);
    if (reset !== 1'b1) begin
      acc = 2'b00; iss_f = 1'b0; g_f = 1'b0;
      tag_log.delete();
    end else begin
      g    = (req_valid == 2'b11) ? prio_m : req_valid[1];
      room = (n_out < DEPTH);
      check("din_valid", 64'(u_din_valid), 64'((|req_valid) && room));
      if (|req_valid)
        check("req_ready", 64'(req_ready), 64'((u_din_ready && room) ? (2'b01 << g) : 2'b00));
      acc   = req_valid & req_ready;
      iss_f = u_din_valid && u_din_ready;
      g_f   = g;
      if (iss_f) begin
        check("din_rs1", u_din_rs1, cur_rs1[g]);
        check("din_rs2", u_din_rs2, cur_rs2[g]);
        check("din_insn30", 64'(u_din_insn30), 64'(cur_x[g]));
        e.tag = g;
        e.rd  = bmat_ref(cur_rs1[g], cur_rs2[g], cur_x[g]);
        sb.push_back(e);
        tag_log.push_back(int'(req_ready[1]));
        iss_cnt[g]++;
      end
    end
  end

  // Response monitor: routing checks and in-order scoreboard pop
  initial forever begin
    logic [1:0] erv;
    logic       eudr;
    logic       h;
    exp_t       e;
    @(negedge clock);
    if (reset !== 1'b1) begin
      sb.delete(); ret_f = 1'b0; err_f = 1'b0;
    end else begin
      h    = (sb.size() > 0) ? sb[0].tag : 1'b0;
      erv  = 2'b00;
      eudr = 1'b0;
      if (n_out > 0) begin
        erv  = u_dout_valid ? (2'b01 << h) : 2'b00;
        eudr = rsp_ready[h];
      end
      check("rsp_valid", 64'(rsp_valid), 64'(erv));
      check("u_dout_ready", 64'(u_dout_ready), 64'(eudr));
      check("err", 64'(err), 64'(err_m));
      ret_f = u_dout_valid && u_dout_ready;
      err_f = u_dout_valid && (n_out == 0);
      if (ret_f) begin
        check("retire_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_rd", rsp_rd, e.rd);
          check("rsp_owner", 64'(rsp_valid[1]), 64'(e.tag));
          resp_cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_u_dout_ready", 64'(u_dout_ready), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_din_valid", 64'(u_din_valid), 64'd0);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((rq0.size() != 0 || rq1.size() != 0 || cur_v != 2'b00 || n_out != 0) && n < max_cyc) begin
      @(posedge clock);
      #2;
      n++;
    end
    check({name, "_drain_in_time"}, 64'(n < max_cyc), 64'd1);
  endtask

  initial begin
    int b0;
    int b1;
    int r0;
    int lats [2];
    reset = 1'b0; req_valid = 2'b00; req_rs1 = '0; req_rs2 = '0; req_insn30 = 2'b00;
    rsp_ready = 2'b00; u_din_ready = 1'b0; u_dout_valid = 1'b0; u_dout_rd = 64'd0;
    lats = '{0, 8};
    do_reset();

    // single requester, identity matrix, xor form
    lat = 2;
    b0 = iss_cnt[0]; b1 = iss_cnt[1]; r0 = resp_cnt;
    rq0.push_back('{rs1: 64'h0102040810204080, rs2: 64'h8040201008040201, x: 1'b1});
    wait_drain("single", 200);
    check("single_issues_r0", 64'(iss_cnt[0] - b0), 64'd1);
    check("single_issues_r1", 64'(iss_cnt[1] - b1), 64'd0);
    check("single_responses", 64'(resp_cnt - r0), 64'd1);

    // contention: alternating tags starting with requester 0
    do_reset();
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      rq0.push_back(rand_op());
      rq1.push_back(rand_op());
    end
    wait_drain("contend", 500);
    check("contend_issues", 64'(tag_log.size()), 64'd16);
    for (int k = 0; k < tag_log.size(); k++)
      check("contend_tag_order", 64'(tag_log[k]), 64'(k % 2));

    // full: unit holds results, six requests pending
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rq0.push_back(rand_op());
      rq1.push_back(rand_op());
    end
    repeat (12) @(posedge clock);
    @(negedge clock);
    check("full_issues", 64'(tag_log.size()), 64'd4);
    check("full_req_ready", 64'(req_ready), 64'd0);
    check("full_din_valid", 64'(u_din_valid), 64'd0);
    hold = 1'b0;
    wait_drain("full", 500);

    // backpressure on a head owned by requester 1
    do_reset();
    rspr_fix_en = 1'b1;
    rspr_fix = 2'b01;
    r0 = resp_cnt;
    rq1.push_back(rand_op());
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("bp_rsp_valid", 64'(rsp_valid), 64'b10);
    check("bp_u_dout_ready", 64'(u_dout_ready), 64'd0);
    check("bp_no_pop", 64'(resp_cnt - r0), 64'd0);
    rspr_fix = 2'b11;
    @(negedge clock);
    check("bp_release_ready", 64'(u_dout_ready), 64'd1);
    @(posedge clock);
    #2;
    check("bp_popped", 64'(resp_cnt - r0), 64'd1);
    rspr_fix_en = 1'b0;
    wait_drain("bp", 100);

    // spurious result with nothing outstanding
    do_reset();
    repeat (2) @(posedge clock);
    #2;
    u_dout_valid = 1'b1;
    u_dout_rd = {$urandom, $urandom};
    @(posedge clock);
    #2;
    check("spur_err_set", 64'(err), 64'd1);
    repeat (5) @(posedge clock);
    #2;
    check("spur_err_held", 64'(err), 64'd1);
    do_reset();

    // reset with work in flight, then random traffic at two latencies
    p_req = 60; p_dinr = 70; p_rspr = 70; lat = 3;
    for (int k = 0; k < 20; k++) begin
      rq0.push_back(rand_op());
      rq1.push_back(rand_op());
    end
    repeat (15) @(posedge clock);
    for (int li = 0; li < 2; li++) begin
      lat = lats[li];
      do_reset();
      b0 = iss_cnt[0]; b1 = iss_cnt[1]; r0 = resp_cnt;
      for (int k = 0; k < 1000; k++) begin
        rq0.push_back(rand_op());
        rq1.push_back(rand_op());
      end
      wait_drain("random", 40000);
      check("random_issues_r0", 64'(iss_cnt[0] - b0), 64'd1000);
      check("random_issues_r1", 64'(iss_cnt[1] - b1), 64'd1000);
      check("random_responses", 64'(resp_cnt - r0), 64'd2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
